// File: rtl/ppu_pkg.sv
// Shared float-format sizes, special-class encoding and scheduler FSM states
// for the float decode scheduler.
package ppu_pkg;

    localparam int FLOAT_EXP_SIZE_64  = 11;
    localparam int FLOAT_MANT_SIZE_64 = 52;
    localparam int FLOAT_EXP_SIZE_32  = 8;
    localparam int FLOAT_MANT_SIZE_32 = 23;

    function automatic int float_exp_size(input int fsize);
        return (fsize == 32) ? FLOAT_EXP_SIZE_32 : FLOAT_EXP_SIZE_64;
    endfunction

    function automatic int float_mant_size(input int fsize);
        return (fsize == 32) ? FLOAT_MANT_SIZE_32 : FLOAT_MANT_SIZE_64;
    endfunction

    typedef enum logic [1:0] {
        SPC_NORMAL = 2'b00,
        SPC_ZERO   = 2'b01,
        SPC_INF    = 2'b10,
        SPC_NAN    = 2'b11
    } float_special_e;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/float_decode_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at rr_ptr,
// pointer advances past the winner on each accept.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any_req
);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    assign any_req = |req;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/float_decode_scheduler.sv
// Time-multiplexed IEEE float decoder shared by N_REQ requesters with a
// one-entry output slot. Define FLOAT_DEC_SPECIAL_EN to add out_special.
module float_decode_scheduler
    import ppu_pkg::*;
#(
    parameter int FSIZE = 64,
    parameter int N_REQ = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_REQ-1:0]                        req_valid,
    input  logic [N_REQ*FSIZE-1:0]                  req_bits,
    output logic [N_REQ-1:0]                        req_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_sign,
    output logic signed [float_exp_size(FSIZE)-1:0] out_exp,
    output logic [float_mant_size(FSIZE)-1:0]       out_frac,
    output logic [$clog2(N_REQ)-1:0]                out_id
`ifdef FLOAT_DEC_SPECIAL_EN
    ,
    output logic [1:0]                              out_special
`endif
);

    localparam int EXP_W  = float_exp_size(FSIZE);
    localparam int MANT_W = float_mant_size(FSIZE);
    localparam int IW     = $clog2(N_REQ);
    localparam logic [EXP_W-1:0] EXP_BIAS = {1'b0, {(EXP_W-1){1'b1}}};

    sched_state_e              state_q, state_d;
    logic                      slot_free, accept, any_req;
    logic [N_REQ-1:0]          grant;
    logic [IW-1:0]             grant_idx;
    logic [FSIZE-1:0]          sel_bits;
    logic [EXP_W-1:0]          biased_exp;
    logic                      sign_q, sign_d;
    logic signed [EXP_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]         frac_q, frac_d;
    logic [IW-1:0]             id_q, id_d;

    // Slot is free when empty or when the held result leaves this cycle.
    assign slot_free = rst_n && ((state_q == ST_EMPTY) || out_ready);
    assign accept    = slot_free && any_req;
    assign req_ready = slot_free ? grant : '0;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        sel_bits = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_bits = req_bits[i*FSIZE +: FSIZE];
            end
        end
    end

    assign biased_exp = sel_bits[FSIZE-2 -: EXP_W];

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        id_d    = id_q;
        if (state_q == ST_EMPTY) begin
            if (accept) state_d = ST_FULL;
        end else begin
            if (out_ready && !accept) state_d = ST_EMPTY;
        end
        // Subnormals intentionally use the same unbiasing, no normalisation.
        if (accept) begin
            sign_d = sel_bits[FSIZE-1];
            exp_d  = signed'(biased_exp - EXP_BIAS);
            frac_d = sel_bits[MANT_W-1:0];
            id_d   = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            frac_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_sign  = sign_q;
    assign out_exp   = exp_q;
    assign out_frac  = frac_q;
    assign out_id    = id_q;

`ifdef FLOAT_DEC_SPECIAL_EN
    float_special_e special_q, special_d;

    always_comb begin
        special_d = special_q;
        if (accept) begin
            if (biased_exp == '0) begin
                special_d = SPC_ZERO;
            end else if (biased_exp == '1) begin
                special_d = (sel_bits[MANT_W-1:0] == '0) ? SPC_INF : SPC_NAN;
            end else begin
                special_d = SPC_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_q <= SPC_NORMAL;
        end else begin
            special_q <= special_d;
        end
    end

    assign out_special = special_q;
`endif

endmodule

// File: tb/tb_float_decode_scheduler.sv
// Scoreboard bench for float_decode_scheduler (FSIZE=64, N_REQ=2): a driver
// walks a cycle table and queues expected results, a monitor checks them.
module tb_float_decode_scheduler;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [127:0] req_bits;
    logic [1:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic signed [10:0] out_exp;
    logic [51:0]  out_frac;
    logic [0:0]   out_id;
    logic [1:0]   out_special;

    float_decode_scheduler #(.FSIZE(64), .N_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_bits  (req_bits),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_id    (out_id)
`ifdef FLOAT_DEC_SPECIAL_EN
        ,
        .out_special (out_special)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              sign;
        logic signed [10:0] exp;
        logic [51:0]       frac;
        logic              id;
        logic [1:0]        spc;
    } exp_t;

    exp_t sb_q[$];

    logic [63:0]        op_bits [8];
    logic               op_sign [8];
    logic signed [10:0] op_exp  [8];
    logic [51:0]        op_frac [8];
    logic [1:0]         op_spc  [8];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Hand-decoded operand table: A,B,C(+inf),D(NaN),E(+0),F(1.0),G(min subnormal),H(-4.0)
    initial begin
        op_bits[0] = 64'h405ee00000000000; op_sign[0] = 1'b0; op_exp[0] = 11'sd6;  op_frac[0] = 52'hee00000000000; op_spc[0] = 2'b00;
        op_bits[1] = 64'hBFE0000000000000; op_sign[1] = 1'b1; op_exp[1] = 11'h7FF; op_frac[1] = 52'h0;             op_spc[1] = 2'b00;
        op_bits[2] = 64'h7FF0000000000000; op_sign[2] = 1'b0; op_exp[2] = 11'h400; op_frac[2] = 52'h0;             op_spc[2] = 2'b10;
        op_bits[3] = 64'h7FF8000000000000; op_sign[3] = 1'b0; op_exp[3] = 11'h400; op_frac[3] = 52'h8000000000000; op_spc[3] = 2'b11;
        op_bits[4] = 64'h0000000000000000; op_sign[4] = 1'b0; op_exp[4] = 11'h401; op_frac[4] = 52'h0;             op_spc[4] = 2'b01;
        op_bits[5] = 64'h3FF0000000000000; op_sign[5] = 1'b0; op_exp[5] = 11'sd0;  op_frac[5] = 52'h0;             op_spc[5] = 2'b00;
        op_bits[6] = 64'h0000000000000001; op_sign[6] = 1'b0; op_exp[6] = 11'h401; op_frac[6] = 52'h1;             op_spc[6] = 2'b01;
        op_bits[7] = 64'hC010000000000000; op_sign[7] = 1'b1; op_exp[7] = 11'sd2;  op_frac[7] = 52'h0;             op_spc[7] = 2'b00;
    end

    task automatic row(input logic [1:0] rv, input int o0, input int o1, input logic ordy,
                       input logic [1:0] er, input logic ev);
        exp_t e;
        int   g;
        @(posedge clk);
        #1;
        req_valid = rv;
        req_bits  = {op_bits[o1], op_bits[o0]};
        out_ready = ordy;
        @(negedge clk);
        chk("req_ready", {62'b0, req_ready}, {62'b0, er});
        chk("out_valid", {63'b0, out_valid}, {63'b0, ev});
        if (er != 2'b00) begin
            g      = er[1] ? o1 : o0;
            e.sign = op_sign[g];
            e.exp  = op_exp[g];
            e.frac = op_frac[g];
            e.id   = er[1];
            e.spc  = op_spc[g];
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got id=%0d exp=%0d, expected no result at %0t", out_id, out_exp, $time);
            end else begin
                chk("out_sign", {63'b0, out_sign}, {63'b0, sb_q[0].sign});
                chk("out_exp",  {{53{out_exp[10]}}, out_exp}, {{53{sb_q[0].exp[10]}}, sb_q[0].exp});
                chk("out_frac", {12'b0, out_frac}, {12'b0, sb_q[0].frac});
                chk("out_id",   {63'b0, out_id}, {63'b0, sb_q[0].id});
`ifdef FLOAT_DEC_SPECIAL_EN
                chk("out_special", {62'b0, out_special}, {62'b0, sb_q[0].spc});
`endif
                if (out_ready) begin
                    $display("result id=%0d sign=%0d exp=%0d frac=%h at %0t", out_id, out_sign, out_exp, out_frac, $time);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_bits  = {64'hBFE0000000000000, 64'h405ee00000000000};
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
        chk("rst_out_exp",   {53'b0, out_exp}, 64'd0);
        chk("rst_out_frac",  {12'b0, out_frac}, 64'd0);
        chk("rst_out_sign_id", {62'b0, out_sign, out_id}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        #2 rst_n = 1'b1;

        // single request, idle
        row(2'b01, 0, 0, 1'b1, 2'b01, 1'b0);
        row(2'b00, 0, 0, 1'b1, 2'b00, 1'b1);
        row(2'b00, 0, 0, 1'b1, 2'b00, 1'b0);
        // contention: rr_ptr is 1 here, so grants go 1,0,1,0 back-to-back
        row(2'b11, 1, 2, 1'b1, 2'b10, 1'b0);
        row(2'b11, 1, 3, 1'b1, 2'b01, 1'b1);
        row(2'b11, 4, 3, 1'b1, 2'b10, 1'b1);
        row(2'b11, 4, 6, 1'b1, 2'b01, 1'b1);
        row(2'b00, 0, 0, 1'b1, 2'b00, 1'b1);
        // backpressure for 5 cycles, then same-cycle accept on release
        row(2'b01, 5, 0, 1'b1, 2'b01, 1'b0);
        for (int k = 0; k < 5; k++) row(2'b11, 7, 0, 1'b0, 2'b00, 1'b1);
        row(2'b11, 7, 0, 1'b1, 2'b10, 1'b1);
        row(2'b00, 0, 0, 1'b1, 2'b00, 1'b1);
        // fill slot leaving rr_ptr=1, then reset while FULL
        row(2'b01, 6, 0, 1'b0, 2'b01, 1'b0);
        row(2'b00, 0, 0, 1'b0, 2'b00, 1'b1);
        #2;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_bits  = {op_bits[1], op_bits[7]};
        #1;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_req_ready", {62'b0, req_ready}, 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        req_valid = 2'b00;
        #2 rst_n = 1'b1;
        // tie after reset must go to requester 0
        row(2'b11, 7, 1, 1'b1, 2'b01, 1'b0);
        row(2'b00, 0, 0, 1'b1, 2'b00, 1'b1);
        row(2'b00, 0, 0, 1'b1, 2'b00, 1'b0);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
